// File: rtl/uart_fifo_xcvr.sv
// uart_fifo_xcvr: full-duplex UART with TX/RX FIFOs, optional parity, 1/2 stop bits and sticky RX errors.
// TX output is registered, so ser_tx trails the TX state by one clock.
module uart_fifo_xcvr #(
    parameter int CLKS_PER_BIT = 4167,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 resetb,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 ser_tx,
    input  logic                 ser_rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    input  logic                 err_clear
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] DATA_END = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_END = 4'(STOP_BITS - 1);
    localparam logic PAR_EN = 1'(PARITY_EN);
    localparam logic PAR_ODD = 1'(PARITY_ODD);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic tx_empty, tx_full, tx_push, tx_pop, rx_full, rx_push, rx_pop;
    state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [3:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic tx_par_q, tx_par_d, rx_par_q, rx_par_d, ser_tx_q, ser_tx_d;
    logic rx_s1_q, rx_s2_q, rx_s3_q, tx_bit_end, rx_hit, rx_done;
    logic frame_set, par_set, ovr_set, rx_ok;
    logic frame_q, par_q, ovr_q;

    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign tx_ready = ~tx_full;
    assign tx_push  = tx_valid & ~tx_full;
    assign tx_busy  = (tx_state_q != IDLE) | ~tx_empty;
    assign ser_tx   = ser_tx_q;
    assign rx_valid = rx_wp_q != rx_rp_q;
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign rx_data  = rx_valid ? rx_mem[rx_rp_q[AW-1:0]] : '0;
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_frame_err  = frame_q;
    assign rx_parity_err = par_q;
    assign rx_overrun    = ovr_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            tx_wp_q <= '0; tx_rp_q <= '0; rx_wp_q <= '0; rx_rp_q <= '0;
            tx_state_q <= IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0; tx_par_q <= 1'b0;
            rx_state_q <= IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0; rx_par_q <= 1'b0;
            ser_tx_q <= 1'b1; rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
            frame_q <= 1'b0; par_q <= 1'b0; ovr_q <= 1'b0;
        end else begin
            tx_wp_q <= tx_wp_q + {{AW{1'b0}}, tx_push};
            tx_rp_q <= tx_rp_q + {{AW{1'b0}}, tx_pop};
            rx_wp_q <= rx_wp_q + {{AW{1'b0}}, rx_push};
            rx_rp_q <= rx_rp_q + {{AW{1'b0}}, rx_pop};
            tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d;
            tx_sh_q <= tx_sh_d; tx_par_q <= tx_par_d; ser_tx_q <= ser_tx_d;
            rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d;
            rx_sh_q <= rx_sh_d; rx_par_q <= rx_par_d;
            rx_s1_q <= ser_rx; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
            frame_q <= frame_set | (frame_q & ~err_clear);
            par_q <= par_set | (par_q & ~err_clear);
            ovr_q <= ovr_set | (ovr_q & ~err_clear);
        end
    end

    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wp_q[AW-1:0]] <= tx_data;
        if (rx_push) rx_mem[rx_wp_q[AW-1:0]] <= rx_sh_q;
    end

    always_comb begin
        tx_bit_end = tx_cnt_q == BIT_END;
        tx_state_d = tx_state_q;
        tx_cnt_d = (tx_state_q == IDLE || tx_bit_end) ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d = tx_bit_q;
        tx_sh_d = tx_sh_q;
        tx_par_d = tx_par_q;
        tx_pop = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_pop = ~tx_empty;
                tx_state_d = tx_empty ? IDLE : START;
            end
            START: begin
                tx_state_d = tx_bit_end ? DATA : START;
                tx_bit_d = tx_bit_end ? '0 : tx_bit_q;
            end
            DATA: if (tx_bit_end) begin
                tx_sh_d = tx_sh_q >> 1;
                tx_bit_d = (tx_bit_q == DATA_END) ? '0 : tx_bit_q + 1'b1;
                tx_state_d = (tx_bit_q != DATA_END) ? DATA : PAR_EN ? PAR : STOP;
            end
            PAR: if (tx_bit_end) begin
                tx_state_d = STOP;
                tx_bit_d = '0;
            end
            STOP: if (tx_bit_end) begin
                tx_bit_d = tx_bit_q + 1'b1;
                if (tx_bit_q == STOP_END) begin
                    tx_pop = ~tx_empty;
                    tx_state_d = tx_empty ? IDLE : START;
                end
            end
            default: tx_state_d = IDLE;
        endcase
        if (tx_pop) begin
            tx_sh_d = tx_mem[tx_rp_q[AW-1:0]];
            tx_par_d = ^tx_mem[tx_rp_q[AW-1:0]] ^ PAR_ODD;
        end
    end

    always_comb ser_tx_d = (tx_state_q == START) ? 1'b0 : (tx_state_q == DATA) ? tx_sh_q[0] :
                           (tx_state_q == PAR) ? tx_par_q : 1'b1;

    // START waits half a bit from the synchronised falling edge, later bits a full bit each
    always_comb begin
        rx_hit = rx_cnt_q == ((rx_state_q == START) ? HALF_END : BIT_END);
        rx_state_d = rx_state_q;
        rx_cnt_d = (rx_state_q == IDLE || rx_hit) ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;
        rx_par_d = rx_par_q;
        rx_done = 1'b0;
        case (rx_state_q)
            IDLE: rx_state_d = (rx_s3_q & ~rx_s2_q) ? START : IDLE;
            START: if (rx_hit) begin
                rx_state_d = rx_s2_q ? IDLE : DATA;
                rx_bit_d = '0;
            end
            DATA: if (rx_hit) begin
                rx_sh_d = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = (rx_bit_q == DATA_END) ? '0 : rx_bit_q + 1'b1;
                rx_state_d = (rx_bit_q != DATA_END) ? DATA : PAR_EN ? PAR : STOP;
            end
            PAR: if (rx_hit) begin
                rx_par_d = rx_s2_q;
                rx_state_d = STOP;
            end
            STOP: if (rx_hit) begin
                rx_done = 1'b1;
                rx_state_d = IDLE;
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_set = rx_done & ~rx_s2_q;
        par_set = rx_done & PAR_EN & (rx_par_q ^ (^rx_sh_q) ^ PAR_ODD);
        rx_ok = rx_done & ~frame_set & ~par_set;
        rx_push = rx_ok & (~rx_full | rx_pop);
        ovr_set = rx_ok & rx_full & ~rx_pop;
    end
endmodule

// File: tb/tb_uart_fifo_xcvr.sv
// tb_uart_fifo_xcvr: directed bench for the UART transceiver at 16 clocks per bit.
// One 8N1 instance drives/reads the pins directly; a second odd-parity instance is looped back on itself.
module tb_uart_fifo_xcvr;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetb, tx_valid, tx_ready, tx_busy, ser_tx, rx_line, rx_valid, rx_ready;
    logic frame_err, parity_err, overrun, err_clear;
    logic [7:0] tx_data, rx_data;
    logic p_tx_valid, p_tx_ready, p_tx_busy, p_ser_tx, p_rx_valid, p_rx_ready;
    logic p_frame_err, p_parity_err, p_overrun, p_err_clear;
    logic [7:0] p_tx_data, p_rx_data;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;
    vec_t vecs [9];

    int total = 0;
    int passed = 0;

    uart_fifo_xcvr #(.CLKS_PER_BIT(16)) u_dut (
        .clock(clk), .resetb(resetb), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .tx_busy(tx_busy), .ser_tx(ser_tx), .ser_rx(rx_line), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .rx_frame_err(frame_err), .rx_parity_err(parity_err),
        .rx_overrun(overrun), .err_clear(err_clear)
    );

    uart_fifo_xcvr #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1)) u_par (
        .clock(clk), .resetb(resetb), .tx_valid(p_tx_valid), .tx_data(p_tx_data), .tx_ready(p_tx_ready),
        .tx_busy(p_tx_busy), .ser_tx(p_ser_tx), .ser_rx(p_ser_tx), .rx_valid(p_rx_valid),
        .rx_data(p_rx_data), .rx_ready(p_rx_ready), .rx_frame_err(p_frame_err),
        .rx_parity_err(p_parity_err), .rx_overrun(p_overrun), .err_clear(p_err_clear)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drives one 8N1 frame on rx_line; rx_ready pulses during iteration pop_at only
    task automatic send_frame(input logic [7:0] data, input logic stop, input int pop_at);
        logic [9:0] f;
        f = {stop, data, 1'b0};
        for (int i = 0; i < 160; i++) begin
            rx_line = f[i / 16];
            rx_ready = (i == pop_at);
            tick(1);
        end
        rx_line = 1'b1;
        rx_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] cap;
        int n;
        vecs[0] = '{8'h0F, 10'h21E};
        vecs[1] = '{8'h3D, 10'h27A};
        vecs[2] = '{8'hA5, 10'h34A};
        vecs[3] = '{8'h00, 10'h200};
        vecs[4] = '{8'hFF, 10'h3FE};
        vecs[5] = '{8'h01, 10'h202};
        vecs[6] = '{8'h80, 10'h300};
        vecs[7] = '{8'h55, 10'h2AA};
        vecs[8] = '{8'hAA, 10'h354};
        resetb = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_line = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
        p_tx_valid = 1'b0; p_tx_data = '0; p_rx_ready = 1'b0; p_err_clear = 1'b0;
        tick(3);
        chk("rst_ser_tx", ser_tx, 1);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_flags", {frame_err, parity_err, overrun}, 0);
        resetb = 1'b1;
        tick(2);

        // single frame: exact start latency, bit values, busy release
        tx_data = 8'h0F; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("busy_after_write", tx_busy, 1);
        tick(1);
        chk("ser_tx_high_at_pop", ser_tx, 1);
        tick(1);
        chk("ser_tx_start_low", ser_tx, 0);
        tick(8);
        for (int b = 0; b < 10; b++) begin
            cap[b] = ser_tx;
            if (b < 9) tick(16);
        end
        chk("frame_0x0F", cap, vecs[0].frame);
        tick(6);
        chk("busy_at_160", tx_busy, 1);
        tick(1);
        chk("idle_at_161", tx_busy, 0);
        tick(5);

        // nine back-to-back writes fill the FIFO; the tenth is dropped
        for (int i = 0; i < 10; i++) begin
            tx_data = (i < 9) ? vecs[i].data : 8'h77;
            tx_valid = 1'b1;
            if (i == 8) chk("tx_ready_7_queued", tx_ready, 1);
            if (i == 9) chk("tx_ready_full", tx_ready, 0);
            tick(1);
        end
        tx_valid = 1'b0;
        tick(1);
        for (int k = 0; k < 9; k++) begin
            for (int b = 0; b < 10; b++) begin
                cap[b] = ser_tx;
                tick(16);
            end
            chk($sformatf("b2b_frame_%0d", k), cap, vecs[k].frame);
        end
        chk("dropped_write_not_sent", ser_tx, 1);
        chk("b2b_idle", tx_busy, 0);

        // odd-parity loopback
        p_tx_data = 8'h3D; p_tx_valid = 1'b1;
        tick(1);
        p_tx_valid = 1'b0;
        tick(154);
        chk("odd_parity_bit", p_ser_tx, 0);
        n = 0;
        while (!p_rx_valid && n < 200) begin
            tick(1);
            n++;
        end
        chk("loop_rx_valid", p_rx_valid, 1);
        chk("loop_rx_data", p_rx_data, 8'h3D);
        chk("loop_errs", {p_frame_err, p_parity_err, p_overrun}, 0);
        p_rx_ready = 1'b1;
        tick(1);
        p_rx_ready = 1'b0;
        chk("loop_popped", p_rx_valid, 0);

        // stop bit low
        send_frame(8'h55, 1'b0, -1);
        chk("frame_err_set", frame_err, 1);
        chk("frame_err_dropped", rx_valid, 0);
        chk("frame_err_no_parity", parity_err, 0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("frame_err_cleared", frame_err, 0);

        // quarter-bit glitch
        rx_line = 1'b0;
        tick(4);
        rx_line = 1'b1;
        tick(40);
        chk("glitch_no_byte", rx_valid, 0);
        chk("glitch_no_flags", {frame_err, parity_err, overrun}, 0);

        // overrun: nine frames, no pops
        for (int k = 0; k < 9; k++) send_frame(vecs[k].data, 1'b1, -1);
        chk("overrun_set", overrun, 1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("ovr_order_%0d", k), rx_data, vecs[k].data);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        chk("ovr_drained", rx_valid, 0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // ninth push coincides with a pop: both succeed
        for (int k = 0; k < 8; k++) send_frame(vecs[k].data, 1'b1, -1);
        send_frame(vecs[8].data, 1'b1, 154);
        chk("pop_push_no_overrun", overrun, 0);
        for (int k = 1; k < 9; k++) begin
            chk($sformatf("pp_order_%0d", k), rx_data, vecs[k].data);
            rx_ready = 1'b1;
            tick(1);
            rx_ready = 1'b0;
        end
        chk("pp_drained", rx_valid, 0);

        // reset mid-frame
        tx_data = 8'h00; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(40);
        chk("mid_frame_low", ser_tx, 0);
        resetb = 1'b0;
        #1;
        chk("async_rst_ser_tx", ser_tx, 1);
        chk("async_rst_busy", tx_busy, 0);
        #3;
        resetb = 1'b1;
        tick(200);
        chk("no_resume_ser_tx", ser_tx, 1);
        chk("no_resume_busy", tx_busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
